store_buffer: RTL and testbench

//  Posted-write buffer sitting directly upstream of Data_Memory in the MEM stage.

---
 rtl/store_buffer.sv | 169 ++++++++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer in front of Data_Memory.
// Stores are accepted in a single cycle and drained oldest-first whenever the
// memory port is free. Loads own the port, read it combinationally and take
// the youngest buffered copy of their address when one exists. A store to an
// address that is already buffered overwrites that entry in place.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cpu_store/cpu_load/cpu_addr/cpu_wdata   pipeline request
//   cpu_rdata                     load data (combinational)
//   cpu_stall                     store not accepted this cycle
//   mem_addr/mem_write_data/mem_write/mem_read/mem_read_data  Data_Memory port
//   count/full/empty              occupancy

// One buffer slot: holds {addr,data} and compares its address with the CPU's.
module store_buffer_entry #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              hit
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (wr_en) begin
            addr_d = wr_addr;
            data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign addr = addr_q;
    assign data = data_q;
    assign hit  = (addr_q == cmp_addr);
endmodule

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_store,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_hit;
    logic [DEPTH-1:0]             ent_we;

    logic          drain, store_req, push, coalesce;
    logic          fwd_hit, st_hit;
    logic [PW-1:0] fwd_sel, st_sel, idx;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_entry
            store_buffer_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_entry (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (ent_we[g]),
                .wr_addr  (cpu_addr),
                .wr_data  (cpu_wdata),
                .cmp_addr (cpu_addr),
                .addr     (ent_addr[g]),
                .data     (ent_data[g]),
                .hit      (ent_hit[g])
            );
        end
    endgenerate

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        // Nothing drains while reset is high: buffered stores are discarded.
        drain   = !empty && !cpu_load && !reset;
        fwd_hit = 1'b0;
        fwd_sel = '0;
        st_hit  = 1'b0;
        st_sel  = '0;
        idx     = '0;
        // Walk oldest -> youngest so the last match found is the youngest.
        // The store match skips the head when it is leaving this cycle, so a
        // store never coalesces into data already on its way to memory.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && ent_hit[idx]) begin
                fwd_hit = 1'b1;
                fwd_sel = idx;
                if (!(drain && k == 0)) begin
                    st_hit = 1'b1;
                    st_sel = idx;
                end
            end
        end

        store_req = cpu_store && !cpu_load;
        coalesce  = store_req && st_hit;
        push      = store_req && !st_hit && (!full || drain);
        cpu_stall = cpu_store && (cpu_load || (!st_hit && full && !drain));

        for (int i = 0; i < DEPTH; i++) begin
            ent_we[i] = (push && tail_q == PW'(i)) || (coalesce && st_sel == PW'(i));
        end

        mem_read       = cpu_load;
        mem_write      = drain;
        mem_addr       = cpu_load ? cpu_addr : (drain ? ent_addr[head_q] : '0);
        mem_write_data = drain ? ent_data[head_q] : '0;
        cpu_rdata      = cpu_load ? (fwd_hit ? ent_data[fwd_sel] : mem_read_data) : '0;

        head_d  = head_q + {{(PW-1){1'b0}}, drain};
        tail_d  = tail_q + {{(PW-1){1'b0}}, push};
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } ent_t;
    typedef struct packed { logic stall; logic wr; logic rd; logic [2:0] cnt; } stat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_store, cpu_load;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;
    logic [2:0]  count;
    logic        full, empty;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_store(cpu_store), .cpu_load(cpu_load), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Data_Memory stand-in: combinational read, write at the clock edge.
    logic [31:0] mem [0:15];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + i;
        end else if (mem_write) begin
            mem[mem_addr[3:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_addr[3:0]];

    // Reference model state: pending stores oldest-first, expected memory image.
    ent_t        sb_q[$];
    logic [31:0] ref_mem [0:15];

    stat_t stat_q[$];
    ent_t  drain_q[$];
    ent_t  load_q[$];

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0, rst_chk = 1'b0, end_chk = 1'b0, done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Single checking process: pops expectations whenever the DUT shows activity.
    always @(negedge clk) begin
        stat_t s;
        ent_t  e;
        if (rst_chk) begin
            chk("rst_count", 32'(count), 0);
            chk("rst_empty", 32'(empty), 1);
            chk("rst_full", 32'(full), 0);
            chk("rst_mem_write", 32'(mem_write), 0);
            chk("rst_mem_read", 32'(mem_read), 0);
            chk("rst_stall", 32'(cpu_stall), 0);
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
        end
        if (mon_en && stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("stall", 32'(cpu_stall), 32'(s.stall));
            chk("count", 32'(count), 32'(s.cnt));
            chk("full", 32'(full), 32'(s.cnt == 3'(DEPTH)));
            chk("empty", 32'(empty), 32'(s.cnt == 0));
            chk("mem_write", 32'(mem_write), 32'(s.wr));
            chk("mem_read", 32'(mem_read), 32'(s.rd));
            if (mem_write) begin
                if (drain_q.size() == 0) begin
                    chk("unexpected_drain", 32'(mem_write), 0);
                end else begin
                    e = drain_q.pop_front();
                    chk("drain_addr", mem_addr, e.addr);
                    chk("drain_data", mem_write_data, e.data);
                end
            end
            if (mem_read) begin
                if (load_q.size() == 0) begin
                    chk("unexpected_load", 32'(mem_read), 0);
                end else begin
                    e = load_q.pop_front();
                    chk("load_addr", mem_addr, e.addr);
                    chk("load_rdata", cpu_rdata, e.data);
                end
            end
            if (!mem_read && !mem_write) begin
                chk("idle_mem_addr", mem_addr, 0);
                chk("idle_rdata", cpu_rdata, 0);
            end
        end
        if (end_chk && !done) begin
            chk("left_drains", drain_q.size(), 0);
            chk("left_loads", load_q.size(), 0);
            chk("left_stats", stat_q.size(), 0);
            chk("final_count", 32'(count), 0);
            for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
            done = 1'b1;
        end
    end

    // One clock of stimulus; the model computes what the DUT must show this
    // cycle, queues it, then advances to the post-edge state.
    task automatic cyc(input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic rs);
        int    n, hit;
        logic  drn, stall, push_new;
        logic [31:0] rd;
        stat_t s;
        @(posedge clk);
        #1;
        reset = rs; cpu_load = ld; cpu_store = st; cpu_addr = a; cpu_wdata = d;
        n        = sb_q.size();
        drn      = !rs && n > 0 && !ld;
        stall    = 1'b0;
        push_new = 1'b0;
        if (ld) begin
            rd = ref_mem[a[3:0]];
            for (int i = 0; i < n; i++) if (sb_q[i].addr == a) rd = sb_q[i].data;
            load_q.push_back('{addr: a, data: rd});
        end
        if (st && ld) begin
            stall = 1'b1;
        end else if (st) begin
            hit = -1;
            for (int i = (drn ? 1 : 0); i < n; i++) if (sb_q[i].addr == a) hit = i;
            if (hit >= 0) sb_q[hit].data = d;
            else if (n < DEPTH || drn) push_new = 1'b1;
            else stall = 1'b1;
        end
        s.stall = stall; s.wr = drn; s.rd = ld; s.cnt = 3'(n);
        stat_q.push_back(s);
        if (drn) begin
            drain_q.push_back(sb_q[0]);
            ref_mem[sb_q[0].addr[3:0]] = sb_q[0].data;
            void'(sb_q.pop_front());
        end
        if (push_new) sb_q.push_back('{addr: a, data: d});
        if (rs) sb_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic ld, st, rs;
        logic [31:0] a;
        reset = 1'b1; mem_init = 1'b1;
        cpu_load = 1'b0; cpu_store = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 + i;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0; rst_chk = 1'b1;
        @(posedge clk);
        #1 rst_chk = 1'b0; reset = 1'b0; mon_en = 1'b1;

        // Single store drains on the next idle cycle.
        cyc(0, 1, 32'd3, 32'hA5A5_0001, 0); idle(2);
        // Load right after a store forwards and blocks the drain.
        cyc(0, 1, 32'd5, 32'h11, 0); cyc(1, 0, 32'd5, 0, 0); idle(2);
        // Rewriting the same address while loads hold the port.
        cyc(0, 1, 32'd7, 32'd1, 0); cyc(1, 1, 32'd7, 32'd2, 0);
        cyc(1, 0, 32'd7, 0, 0); cyc(0, 1, 32'd7, 32'd2, 0); idle(2);
        // Stores alongside a held load are stalled; then released.
        for (int i = 8; i <= 12; i++) cyc(1, 1, 32'(i), 32'h100 + 32'(i), 0);
        cyc(1, 0, 32'd8, 0, 0);
        for (int i = 8; i <= 12; i++) cyc(0, 1, 32'(i), 32'h100 + 32'(i), 0);
        idle(3);
        // Store to the address currently draining must not merge into it.
        cyc(0, 1, 32'd8, 32'hAA, 0); cyc(0, 1, 32'd8, 32'hFF, 0);
        cyc(1, 0, 32'd8, 0, 0); idle(2);
        // Reset with a pending store discards it.
        cyc(0, 1, 32'd1, 32'hDEAD, 0); cyc(1, 0, 32'd1, 0, 0);
        cyc(0, 0, 0, 0, 1); idle(2);

        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom % 10) < 3;
            st = ($urandom % 10) < 5;
            rs = ($urandom % 300) == 0;
            a  = (($urandom % 4) == 0) ? 32'($urandom % 16) : 32'($urandom % 4);
            if (rs) begin ld = 1'b0; st = 1'b0; end
            cyc(ld, st, a, $urandom, rs);
        end
        idle(DEPTH + 2);

        @(posedge clk);
        #1 end_chk = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        if (!done) begin
            $display("FAIL end_check: got 0 expected 1");
            $fatal(1, "final checks did not run");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
